// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI timing controller: 640x480@60 raster defaults,
// substitute colours and the RGB888 word layout used on the pixel FIFO.
package hdmi_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam logic [23:0] DEF_UFLOW_RGB = 24'hFF00FF;
    localparam logic [23:0] DEF_IDLE_RGB  = 24'h000000;

    typedef logic [9:0] cnt_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    function automatic int unsigned timing_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic logic [23:0] pack_rgb888(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {r, g, b};
    endfunction

    localparam int unsigned DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/hdmi_timing_ctrl_if.sv
// Pixel FIFO read port plus the video bundle driven towards the HDMI output path.
interface hdmi_timing_ctrl_if;

    logic        pix_empty;
    logic        pix_rd;
    logic [23:0] pix_data;
    logic [7:0]  RED;
    logic [7:0]  GREEN;
    logic [7:0]  BLUE;
    logic        HSYNC;
    logic        VSYNC;
    logic        video_de;
    logic        frame_start;

    modport master (
        input  pix_empty, pix_data,
        output pix_rd, RED, GREEN, BLUE, HSYNC, VSYNC, video_de, frame_start
    );

    modport slave (
        output pix_empty, pix_data,
        input  pix_rd, RED, GREEN, BLUE, HSYNC, VSYNC, video_de, frame_start
    );

endinterface

// File: rtl/video_timing_counter.sv
// Free-running raster counters with active-area, raw sync and frame-boundary decode.
module video_timing_counter
    import hdmi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic clk_pixel,
    input  logic rst,
    output logic active,
    output logic hsync_raw,
    output logic vsync_raw,
    output logic frame_start,
    output logic frame_end
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam cnt_t H_LAST     = 10'(H_TOTAL - 1);
    localparam cnt_t V_LAST     = 10'(V_TOTAL - 1);
    localparam cnt_t H_ACT_END  = 10'(H_ACTIVE);
    localparam cnt_t V_ACT_END  = 10'(V_ACTIVE);
    localparam cnt_t H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam cnt_t H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam cnt_t V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t h_cnt_r;
    cnt_t v_cnt_r;
    logic h_wrap_s;

    // Raster position: h wraps every line, v steps (and wraps) on the same edge.
    always_ff @(posedge clk_pixel or negedge rst) begin
        if (!rst) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (h_wrap_s) begin
            h_cnt_r <= 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= 10'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Region decode; vsync spans whole lines because it depends on v alone.
    always_comb begin
        h_wrap_s    = (h_cnt_r == H_LAST);
        active      = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
        hsync_raw   = (h_cnt_r >= H_SYNC_BEG) && (h_cnt_r < H_SYNC_END);
        vsync_raw   = (v_cnt_r >= V_SYNC_BEG) && (v_cnt_r < V_SYNC_END);
        frame_start = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
        frame_end   = h_wrap_s && (v_cnt_r == V_LAST);
    end

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// HDMI video timing controller: raster timing, frame-aligned run control, pixel FIFO
// sequencing with underflow substitution, and one registered output stage.
module hdmi_timing_ctrl
    import hdmi_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter logic        SYNC_POL  = 1'b0,
    parameter logic [23:0] UFLOW_RGB = DEF_UFLOW_RGB,
    parameter logic [23:0] IDLE_RGB  = DEF_IDLE_RGB
) (
    input  logic               clk_pixel,
    input  logic               rst,
    input  logic               en,
    input  logic               underflow_clr,
    output logic               running,
    output logic               underflow,
    hdmi_timing_ctrl_if.master bus
);

    logic    active_s;
    logic    hsync_raw_s;
    logic    vsync_raw_s;
    logic    frame_start_s;
    logic    frame_end_s;
    logic    pix_rd_s;
    logic    uflow_evt_s;
    rgb888_t rgb_nxt_s;

    logic    running_r;
    logic    underflow_r;
    logic    rd_d1_r;
    rgb888_t rgb_r;
    logic    hsync_r;
    logic    vsync_r;
    logic    de_r;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_pixel   (clk_pixel),
        .rst         (rst),
        .active      (active_s),
        .hsync_raw   (hsync_raw_s),
        .vsync_raw   (vsync_raw_s),
        .frame_start (frame_start_s),
        .frame_end   (frame_end_s)
    );

    // Streaming request is only sampled on the last pixel slot of a frame.
    always_ff @(posedge clk_pixel or negedge rst) begin
        if (!rst) begin
            running_r <= 1'b0;
        end else if (frame_end_s) begin
            running_r <= en;
        end else begin
            running_r <= running_r;
        end
    end

    // FIFO strobe, underflow event and colour select, all from the counter stage.
    // Data read in slot h arrives one cycle later, so it fills output slot h+1.
    always_comb begin
        pix_rd_s    = active_s && running_r && !bus.pix_empty;
        uflow_evt_s = active_s && running_r && bus.pix_empty;
        if (!active_s) begin
            rgb_nxt_s = rgb888_t'(24'h000000);
        end else if (!running_r) begin
            rgb_nxt_s = rgb888_t'(IDLE_RGB);
        end else if (rd_d1_r) begin
            rgb_nxt_s = rgb888_t'(bus.pix_data);
        end else begin
            rgb_nxt_s = rgb888_t'(UFLOW_RGB);
        end
    end

    // Sticky underflow flag; a fresh event outranks a simultaneous clear.
    always_ff @(posedge clk_pixel or negedge rst) begin
        if (!rst) begin
            underflow_r <= 1'b0;
        end else if (uflow_evt_s) begin
            underflow_r <= 1'b1;
        end else if (underflow_clr) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    // Output stage: one register for every video signal, plus the read-valid delay.
    always_ff @(posedge clk_pixel or negedge rst) begin
        if (!rst) begin
            rd_d1_r <= 1'b0;
            rgb_r   <= rgb888_t'(24'h000000);
            de_r    <= 1'b0;
            hsync_r <= ~SYNC_POL;
            vsync_r <= ~SYNC_POL;
        end else begin
            rd_d1_r <= pix_rd_s;
            rgb_r   <= rgb_nxt_s;
            de_r    <= active_s;
            hsync_r <= ~(hsync_raw_s ^ SYNC_POL);
            vsync_r <= ~(vsync_raw_s ^ SYNC_POL);
        end
    end

    assign bus.pix_rd      = pix_rd_s;
    assign bus.frame_start = frame_start_s;
    assign bus.RED         = rgb_r.r;
    assign bus.GREEN       = rgb_r.g;
    assign bus.BLUE        = rgb_r.b;
    assign bus.HSYNC       = hsync_r;
    assign bus.VSYNC       = vsync_r;
    assign bus.video_de    = de_r;
    assign running         = running_r;
    assign underflow       = underflow_r;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Bench for hdmi_timing_ctrl on a shrunken raster (56x19) so several frames fit in a short run.
module tb_hdmi_timing_ctrl;
    import hdmi_pkg::*;

    localparam int HA = 40, HF = 4, HS = 8, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic underflow_clr = 1'b0;
    logic running;
    logic underflow;

    hdmi_timing_ctrl_if vif ();

    hdmi_timing_ctrl #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk_pixel     (clk),
        .rst           (rst),
        .en            (en),
        .underflow_clr (underflow_clr),
        .running       (running),
        .underflow     (underflow),
        .bus           (vif.master)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
        logic        run;
        logic        uf;
    } exp_t;

    typedef struct {
        int   n;
        logic en;
        int   ev;
        int   eh0;
        int   eh1;
        logic clr;
        int   rd;
        logic run;
        logic uf;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[12];
    int          total = 0;
    int          bad = 0;
    int          mh, mv, rd_idx, phase_rd;
    logic        m_run, m_uf, m_prev_rd;
    logic [23:0] cur_word;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h h=%0d v=%0d t=%0t", name, got, exp, mh, mv, $time);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; m_run = 1'b0; m_uf = 1'b0; m_prev_rd = 1'b0;
        sb.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rgb"}, 32'({vif.RED, vif.GREEN, vif.BLUE}), 32'h0);
        chk({tag, "_de"}, 32'(vif.video_de), 32'd0);
        chk({tag, "_pix_rd"}, 32'(vif.pix_rd), 32'd0);
        chk({tag, "_running"}, 32'(running), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
        chk({tag, "_hsync"}, 32'(vif.HSYNC), 32'd1);
        chk({tag, "_vsync"}, 32'(vif.VSYNC), 32'd1);
        chk({tag, "_frame_start"}, 32'(vif.frame_start), 32'd1);
    endtask

    // One pixel slot, entered and left on a falling clock edge.
    task automatic step(input logic en_i, input logic emp_i, input logic clr_i);
        exp_t e;
        logic act, hs_raw, vs_raw, fend, exp_rd;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("video_de", 32'(vif.video_de), 32'(e.de));
            chk("HSYNC", 32'(vif.HSYNC), 32'(e.hs));
            chk("VSYNC", 32'(vif.VSYNC), 32'(e.vs));
            chk("rgb", 32'({vif.RED, vif.GREEN, vif.BLUE}), 32'(e.rgb));
            chk("running", 32'(running), 32'(e.run));
            chk("underflow", 32'(underflow), 32'(e.uf));
        end
        if (m_prev_rd) begin
            cur_word = pack_rgb888(8'h12 + 8'(rd_idx), 8'h34 + 8'(rd_idx), 8'h56 + 8'(rd_idx));
            rd_idx++;
        end
        vif.pix_data = cur_word;
        en = en_i;
        vif.pix_empty = emp_i;
        underflow_clr = clr_i;
        #1;
        act    = (mh < HA) && (mv < VA);
        hs_raw = (mh >= HA + HF) && (mh < HA + HF + HS);
        vs_raw = (mv >= VA + VF) && (mv < VA + VF + VS);
        fend   = (mh == HT - 1) && (mv == VT - 1);
        exp_rd = act && m_run && !emp_i;
        chk("pix_rd", 32'(vif.pix_rd), 32'(exp_rd));
        chk("frame_start", 32'(vif.frame_start), 32'((mh == 0) && (mv == 0)));
        e.de  = act;
        e.hs  = !hs_raw;
        e.vs  = !vs_raw;
        e.rgb = !act ? 24'h000000 : (!m_run ? 24'h000000 : (m_prev_rd ? cur_word : 24'hFF00FF));
        if (act && m_run && emp_i) m_uf = 1'b1;
        else if (clr_i) m_uf = 1'b0;
        if (fend) m_run = en_i;
        e.run = m_run;
        e.uf  = m_uf;
        sb.push_back(e);
        m_prev_rd = exp_rd;
        if (vif.pix_rd) phase_rd++;
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        @(negedge clk);
    endtask

    task automatic run_phase(input int i);
        logic emp, clr;
        phase_rd = 0;
        for (int c = 0; c < tbl[i].n; c++) begin
            emp = (mv == tbl[i].ev) && (mh >= tbl[i].eh0) && (mh <= tbl[i].eh1);
            clr = tbl[i].clr && emp && (mh == tbl[i].eh0);
            step(tbl[i].en, emp, clr);
        end
        chk($sformatf("phase%0d_rd_count", i), 32'(phase_rd), 32'(tbl[i].rd));
        chk($sformatf("phase%0d_running", i), 32'(running), 32'(tbl[i].run));
        chk($sformatf("phase%0d_underflow", i), 32'(underflow), 32'(tbl[i].uf));
    endtask

    initial begin
        //          n    en    ev  eh0 eh1 clr   rd   run   uf
        tbl[0]  = '{280, 1'b0, -1, 0,  0,  1'b0, 0,   1'b0, 1'b0}; // idle, frame 0 lines 0..4
        tbl[1]  = '{784, 1'b1, -1, 0,  0,  1'b0, 0,   1'b1, 1'b0}; // en raised mid-frame
        tbl[2]  = '{278, 1'b1, 4,  46, 46, 1'b0, 198, 1'b1, 1'b0}; // blanking empty ignored
        tbl[3]  = '{56,  1'b1, 5,  10, 12, 1'b0, 37,  1'b1, 1'b1}; // 3-pixel underflow
        tbl[4]  = '{56,  1'b1, 6,  20, 20, 1'b1, 39,  1'b1, 1'b1}; // clear vs new event
        tbl[5]  = '{55,  1'b1, -1, 0,  0,  1'b0, 39,  1'b1, 1'b0};
        tbl[6]  = '{616, 1'b0, -1, 0,  0,  1'b0, 160, 1'b0, 1'b0}; // en dropped at line 8
        tbl[7]  = '{448, 1'b0, -1, 0,  0,  1'b0, 0,   1'b0, 1'b0}; // idle frame
        tbl[8]  = '{616, 1'b1, -1, 0,  0,  1'b0, 0,   1'b1, 1'b0};
        tbl[9]  = '{478, 1'b1, -1, 0,  0,  1'b0, 350, 1'b1, 1'b0}; // stream up to (30,8)
        tbl[10] = '{1064, 1'b1, -1, 0, 0,  1'b0, 0,   1'b1, 1'b0}; // first frame after reset
        tbl[11] = '{112, 1'b1, -1, 0,  0,  1'b0, 80,  1'b1, 1'b0};

        vif.pix_empty = 1'b0;
        vif.pix_data  = 24'h000000;
        cur_word = 24'h000000;
        rd_idx = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        run_phase(0);
        run_phase(1);

        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("first_red", 32'(vif.RED), 32'h12);
        chk("first_green", 32'(vif.GREEN), 32'h34);
        chk("first_blue", 32'(vif.BLUE), 32'h56);

        run_phase(2);
        run_phase(3);
        run_phase(4);

        step(1'b1, 1'b0, 1'b1);
        chk("quiet_clear", 32'(underflow), 32'd0);

        run_phase(5);
        run_phase(6);
        run_phase(7);
        run_phase(8);
        run_phase(9);

        chk("pre_reset_de", 32'(vif.video_de), 32'd1);
        rst = 1'b0;
        #1;
        check_reset("midframe_reset");
        repeat (2) @(negedge clk);
        check_reset("held_reset");
        rst = 1'b1;
        model_reset();

        run_phase(10);
        run_phase(11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_timing_ctrl.md
Name: hdmi_timing_ctrl

Overview:
- Video timing controller and pixel sequencer that drives the RED/GREEN/BLUE/HSYNC/VSYNC/video_de inputs of the HDMI output path. Clocked by the pixel clock.
- Generates CEA 640x480@60 timing with free-running counters.
- Pulls pixels from an upstream pixel FIFO using a 1-cycle-latency read strobe.
- Handles FIFO underflow by substituting a fixed colour and raising a sticky status flag.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
SYNC_POL, 0, sync active level (0 = active-low)
UFLOW_RGB, 24'hFF00FF, colour output on underflow
IDLE_RGB, 24'h000000, colour output in active area while not running

Ports:
clk_pixel  in  1  pixel clock, 25 MHz
rst  in  1  asynchronous active-low reset
en  in  1  request streaming; sampled only at frame boundary
pix_empty  in  1  upstream FIFO empty
pix_rd  out  1  FIFO read strobe; data valid on the next cycle
pix_data  in  24  {R,G,B} from FIFO, valid the cycle after pix_rd
underflow_clr  in  1  clears the underflow flag
RED  out  8  to HDMI path
GREEN  out  8  to HDMI path
BLUE  out  8  to HDMI path
HSYNC  out  1  to HDMI path
VSYNC  out  1  to HDMI path
video_de  out  1  active-video enable
frame_start  out  1  one-cycle pulse at h=0, v=0 (counter stage)
running  out  1  streaming active for the current frame
underflow  out  1  sticky underflow flag

Behaviour:
- Totals: H_TOTAL = 800, V_TOTAL = 525. Counters h_cnt[9:0] and v_cnt[9:0] free-run from reset.
- Counter wrap: h wraps at H_TOTAL-1 to 0 and increments v. v wraps at V_TOTAL-1 to 0 on the same cycle h wraps.
- Active region: active = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync_raw asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync_raw asserted for lines 490..491 over whole lines, changing at h=0.
- Output levels: HSYNC = hsync_raw XNOR SYNC_POL, likewise VSYNC (high when inactive for SYNC_POL=0).
- frame_start: combinational from counter stage, high when h=0 && v=0.
- running register:
  - Loaded from en only on the cycle where h = H_TOTAL-1 and v = V_TOTAL-1.
  - A change of en mid-frame has no effect until the next frame.
  - Reset value 0.
- pix_rd = active && running && !pix_empty, combinational from the counter stage.
- Output stage is one register; latency is exactly 1 clk from the counter stage for all outputs.
- Output stage contents:
  - video_de <= active. Syncs are registered from their raw values.
  - RGB in active area: running && rd_d1 -> pix_data; running && !rd_d1 -> UFLOW_RGB; !running -> IDLE_RGB.
  - RGB outside active area: 0.
- Underflow flag:
  - Set when active && running && pix_empty (counter stage).
  - Cleared by underflow_clr. If set and clear occur in the same cycle, set wins.
  - Blanking-period empties never set the flag.
- Reset values:
  - RED, GREEN, BLUE = 0; video_de = 0; pix_rd = 0; running = 0; underflow = 0.
  - HSYNC and VSYNC at their inactive level; counters = 0.
  - frame_start = 1 immediately out of reset (h=v=0); this is legal.
- Reset mid-frame: all state returns to reset values immediately (async). No partial-line recovery; timing restarts at h=v=0.
- No backpressure to upstream beyond pix_rd. Upstream uses frame_start to realign its read address.

Decomposition:
- Shared package hdmi_pkg: timing constants (640x480 defaults, H_TOTAL/V_TOTAL derivation), colour constants UFLOW_RGB and IDLE_RGB, and an RGB888 packing function.
- One sub-module: video_timing_counter (h/v counters, active/hsync_raw/vsync_raw/frame_start decode). The top holds the run control, FIFO strobe, underflow flag and output register.

Test Plan:
- Reset, then release with en=0 -> the following all hold:
  - frame_start at cycle 0.
  - HSYNC low exactly during output cycles 657..752 of each line (1-cycle latency).
  - video_de high for output cycles 1..640 of lines 0..479; VSYNC low on lines 490..491.
  - RGB = 0 throughout; pix_rd never asserted.
- en=1 raised at line 100 of frame 0 -> running rises after cycle (799,524). First pix_rd is at frame 1, h=0. First pixel on RED/GREEN/BLUE matches the FIFO word (e.g. 24'h123456 gives RED=0x12, GREEN=0x34, BLUE=0x56) one cycle later.
- Streaming, then pix_empty=1 for pixels 10..12 of line 5 -> pix_rd low for those 3 cycles, output 0xFF00FF for 3 pixels, underflow=1 and held. pix_empty during h=700 sets nothing.
- underflow=1, then underflow_clr pulsed in the same cycle as a new underflow event -> underflow remains 1. A clear in a quiet cycle -> 0.
- en dropped mid-frame -> streaming continues to the frame end, then running=0, IDLE_RGB in the active area, no pix_rd.
- rst asserted at h=300, v=200 while streaming -> outputs immediately take reset values. After release, counting restarts at 0 and running=0 until the next frame boundary with en=1.
